// File: rtl/uart_pkt_pkg.sv
// Shared constants for the UART receive packet controller: FSM encoding, default sync byte, error indices.
package uart_pkt_pkg;

    localparam logic [2:0] ST_HUNT    = 3'd0;
    localparam logic [2:0] ST_LEN     = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_CHK     = 3'd3;
    localparam logic [2:0] ST_HOLD    = 3'd4;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    localparam int ERR_CHK = 0;
    localparam int ERR_LEN = 1;
    localparam int ERR_TMO = 2;
    localparam int ERR_OVR = 3;
    localparam int ERR_W   = 4;

endpackage

// File: rtl/pkt_buf_ram.sv
// Payload buffer: DEPTH x 8, synchronous write, asynchronous (combinational) read.
module pkt_buf_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Frames UART bytes into SYNC/LEN/PAYLOAD/CHK packets, buffers the payload and holds it until acked.
// Optional saturating good/error counters when UART_PKT_STATS_EN is defined.
module uart_rx_pkt_ctrl
    import uart_pkt_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 50000,
    localparam int        AW          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [7:0]    rx_data,
    input  logic          rx_done,
    output logic          pkt_ready,
    output logic [7:0]    pkt_len,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    input  logic          pkt_ack,
    output logic          err_chk,
    output logic          err_len,
    output logic          err_timeout,
    output logic          err_overrun
`ifdef UART_PKT_STATS_EN
    ,
    output logic [15:0]   stat_good,
    output logic [15:0]   stat_err
`endif
);

    localparam int         CW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    logic [2:0]       state_q, state_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       sum_q, sum_d;
    logic [7:0]       idx_q, idx_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [CW-1:0]    cnt_q;
    logic             rx_done_q;
    logic             byte_stb;
    logic             active;
    logic             tmo;
    logic             wr_en;
    logic [7:0]       chk_sum;

    // Rising-edge detect: rx_done may stay high for several cycles per byte.
    assign byte_stb = rx_done & ~rx_done_q;
    assign active   = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
    assign tmo      = active && !byte_stb && (cnt_q == CW'(TIMEOUT_CYC));
    assign chk_sum  = sum_q + rx_data;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        err_d   = '0;
        wr_en   = 1'b0;
        case (state_q)
            ST_HUNT: begin
                if (enable && byte_stb && rx_data == SYNC_BYTE) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (!enable) begin
                    state_d = ST_HUNT;
                end else if (byte_stb) begin
                    len_d = rx_data;
                    sum_d = rx_data;
                    idx_d = 8'd0;
                    if (rx_data > MAX_LEN_B) begin
                        err_d[ERR_LEN] = 1'b1;
                        state_d        = ST_HUNT;
                    end else if (rx_data == 8'd0) begin
                        state_d = ST_CHK;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end else if (tmo) begin
                    err_d[ERR_TMO] = 1'b1;
                    state_d        = ST_HUNT;
                end
            end
            ST_PAYLOAD: begin
                if (!enable) begin
                    state_d = ST_HUNT;
                end else if (byte_stb) begin
                    wr_en = 1'b1;
                    sum_d = sum_q + rx_data;
                    if (idx_q == len_q - 8'd1) begin
                        state_d = ST_CHK;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end else if (tmo) begin
                    err_d[ERR_TMO] = 1'b1;
                    state_d        = ST_HUNT;
                end
            end
            ST_CHK: begin
                if (!enable) begin
                    state_d = ST_HUNT;
                end else if (byte_stb) begin
                    if (chk_sum == 8'h00) begin
                        state_d = ST_HOLD;
                    end else begin
                        err_d[ERR_CHK] = 1'b1;
                        state_d        = ST_HUNT;
                    end
                end else if (tmo) begin
                    err_d[ERR_TMO] = 1'b1;
                    state_d        = ST_HUNT;
                end
            end
            ST_HOLD: begin
                // Buffer is owned by the host here; incoming bytes are lost.
                if (byte_stb) begin
                    err_d[ERR_OVR] = 1'b1;
                end
                if (pkt_ack) begin
                    state_d = ST_HUNT;
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_HUNT;
            len_q     <= 8'd0;
            sum_q     <= 8'd0;
            idx_q     <= 8'd0;
            err_q     <= '0;
            rx_done_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            sum_q     <= sum_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            rx_done_q <= rx_done;
            if (byte_stb || !active) begin
                cnt_q <= '0;
            end else if (cnt_q != CW'(TIMEOUT_CYC)) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign pkt_ready   = (state_q == ST_HOLD);
    assign pkt_len     = (state_q == ST_HOLD) ? len_q : 8'd0;
    assign err_chk     = err_q[ERR_CHK];
    assign err_len     = err_q[ERR_LEN];
    assign err_timeout = err_q[ERR_TMO];
    assign err_overrun = err_q[ERR_OVR];

    pkt_buf_ram #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (idx_q[AW-1:0]),
        .wr_data (rx_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

`ifdef UART_PKT_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_good <= 16'd0;
            stat_err  <= 16'd0;
        end else begin
            if (state_q == ST_CHK && state_d == ST_HOLD && stat_good != 16'hFFFF) begin
                stat_good <= stat_good + 16'd1;
            end
            if ((|err_q) && stat_err != 16'hFFFF) begin
                stat_err <= stat_err + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed bench for uart_rx_pkt_ctrl with a short timeout for simulation speed.
module tb_uart_rx_pkt_ctrl;

    localparam int TO = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       pkt_ready;
    logic [7:0] pkt_len;
    logic [3:0] rd_addr = 4'd0;
    logic [7:0] rd_data;
    logic       pkt_ack = 1'b0;
    logic       err_chk, err_len, err_timeout, err_overrun;
`ifdef UART_PKT_STATS_EN
    logic [15:0] stat_good, stat_err;
`endif

    int tests = 0;
    int fails = 0;
    logic       pre_ready, last_ready;
    logic [3:0] last_err, post_err;
    int         n;

    always #5 clk = ~clk;

    uart_rx_pkt_ctrl #(
        .SYNC_BYTE   (8'hA5),
        .MAX_LEN     (16),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .pkt_ready   (pkt_ready),
        .pkt_len     (pkt_len),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .pkt_ack     (pkt_ack),
        .err_chk     (err_chk),
        .err_len     (err_len),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
`ifdef UART_PKT_STATS_EN
        ,
        .stat_good   (stat_good),
        .stat_err    (stat_err)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one byte with rx_done high for 'hold' cycles, then one low cycle.
    task automatic send(input logic [7:0] b, input int hold = 1);
        rx_data   = b;
        rx_done   = 1'b1;
        pre_ready = pkt_ready;
        tick();
        last_err   = {err_chk, err_len, err_timeout, err_overrun};
        last_ready = pkt_ready;
        for (int i = 1; i < hold; i++) tick();
        rx_done = 1'b0;
        tick();
        post_err = {err_chk, err_len, err_timeout, err_overrun};
    endtask

    task automatic ack();
        pkt_ack = 1'b1;
        tick();
        pkt_ack = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        rd_addr = a;
        #1;
        check(tag, {8'h00, rd_data}, {8'h00, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        check("rst_ready", {15'd0, pkt_ready}, 16'd0);
        check("rst_len", {8'd0, pkt_len}, 16'd0);
        check("rst_err", {12'd0, err_chk, err_len, err_timeout, err_overrun}, 16'd0);
`ifdef UART_PKT_STATS_EN
        check("rst_stats", stat_good | stat_err, 16'd0);
`endif

        // Good packet
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h97);
        check("good_pre_ready", {15'd0, pre_ready}, 16'd0);
        check("good_ready_lat", {15'd0, last_ready}, 16'd1);
        check("good_no_err", {12'd0, last_err}, 16'd0);
        check("good_len", {8'd0, pkt_len}, 16'd3);
        read_chk("good_rd0", 4'd0, 8'h11);
        read_chk("good_rd1", 4'd1, 8'h22);
        read_chk("good_rd2", 4'd2, 8'h33);
        ack();
        check("good_ack_ready", {15'd0, pkt_ready}, 16'd0);

        // Bad checksum
        send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
        check("chk_err", {12'd0, last_err}, 16'b1000);
        check("chk_err_1cyc", {12'd0, post_err}, 16'd0);
        check("chk_ready", {15'd0, pkt_ready}, 16'd0);

        // Length violation followed by zero-length packet
        send(8'hA5); send(8'h11);
        check("len_err", {12'd0, last_err}, 16'b0100);
        send(8'hA5); send(8'h00); send(8'h00);
        check("len0_ready", {15'd0, pkt_ready}, 16'd1);
        check("len0_len", {8'd0, pkt_len}, 16'd0);
        ack();

        // Inter-byte timeout
        send(8'hA5); send(8'h02); send(8'h10);
        n = 0;
        while (!err_timeout && n < TO + 20) begin
            tick();
            n++;
        end
        check("tmo_cycles", 16'(n), 16'(TO));
        tick();
        check("tmo_1cyc", {15'd0, err_timeout}, 16'd0);
        send(8'hA5); send(8'h01); send(8'h42); send(8'hBD);
        check("tmo_next_ready", {15'd0, pkt_ready}, 16'd1);
        read_chk("tmo_next_rd0", 4'd0, 8'h42);

        // Overrun while held
        send(8'h55);
        check("ovr_err", {12'd0, last_err}, 16'b0001);
        check("ovr_ready", {15'd0, pkt_ready}, 16'd1);
        check("ovr_len", {8'd0, pkt_len}, 16'd1);
        read_chk("ovr_rd0", 4'd0, 8'h42);
        rx_data = 8'h66;
        rx_done = 1'b1;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (err_overrun) n++;
        end
        rx_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (err_overrun) n++;
        end
        check("ovr_long_done", 16'(n), 16'd1);
        ack();
        check("ovr_ack_ready", {15'd0, pkt_ready}, 16'd0);

        // Every byte with rx_done held for 4 cycles
        send(8'hA5, 4); send(8'h01, 4); send(8'h07, 4); send(8'hF8, 4);
        check("hold4_ready", {15'd0, pkt_ready}, 16'd1);
        check("hold4_len", {8'd0, pkt_len}, 16'd1);
        read_chk("hold4_rd0", 4'd0, 8'h07);
        ack();

        // Disable aborts quietly into HUNT
        send(8'hA5);
        enable = 1'b0;
        tick();
        check("dis_no_err", {12'd0, err_chk, err_len, err_timeout, err_overrun}, 16'd0);
        enable = 1'b1;
        send(8'h00); send(8'h00);
        check("dis_ready", {15'd0, pkt_ready}, 16'd0);

`ifdef UART_PKT_STATS_EN
        check("stat_good", stat_good, 16'd4);
        check("stat_err", stat_err, 16'd5);
`endif

        // Reset mid-payload
        send(8'hA5); send(8'h04); send(8'h01);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("mid_rst_ready", {15'd0, pkt_ready}, 16'd0);
        check("mid_rst_len", {8'd0, pkt_len}, 16'd0);
        check("mid_rst_err", {12'd0, err_chk, err_len, err_timeout, err_overrun}, 16'd0);
`ifdef UART_PKT_STATS_EN
        check("mid_rst_stats", stat_good | stat_err, 16'd0);
`endif
        send(8'hA5); send(8'h00); send(8'h00);
        check("mid_rst_hunt", {15'd0, pkt_ready}, 16'd1);
        ack();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
